aud_player: RTL and testbench
=============================

// Module: aud_player
// PURPOSE
//  Serialises signed 16-bit PCM samples onto the WM8731 DAC serial data line (I2S framing).
//  Sits between the audio DSP and the codec pins. Clocked by the codec bit clock; frame
//  timing comes from the codec DACLRCK. Active only while i_en is high (i.e. during playback).
//  The same sample is sent on both the left (LRCK low) and right (LRCK high) channel.
// PARAMETERS
//  DATA_W   16   sample width in bits; all ports below assume 16
// PORTS
//  i_bclk        in   1       codec bit clock; sole clock, all logic on rising edge
//  i_rst_n       in   1       reset, synchronous, active-low
//  i_daclrck     in   1       codec DAC L/R clock; 0 = left, 1 = right channel
//  i_en          in   1       enable; high only while playing audio (driven with AudDSP)
//  i_dac_data    in   16      signed PCM sample from DSP, two's complement
//  o_aud_dacdat  out  1       serial data to codec, MSB first
// BEHAVIOUR
//  - Reset (i_rst_n==0 at a rising i_bclk edge): state=IDLE, o_aud_dacdat=0, bit counter=0,
//    shift reg=0, lrck_q<=i_daclrck. The lrck_q load prevents a false edge right after reset.
//  - Every cycle: lrck_q<=i_daclrck. lrck_edge = (i_daclrck != lrck_q); both polarities count.
//  - States: IDLE, DELAY, SEND, DONE (shared enum).
//    IDLE : o=0; if i_en && lrck_edge -> latch i_dac_data into shift reg, go DELAY.
//    DELAY: o=0 for exactly one cycle (I2S 1-bit delay) -> SEND, cnt=15.
//    SEND : o=shift[cnt]; cnt decrements each cycle; after cnt==0 cycle -> DONE.
//           Bit 15 is driven in the 1st SEND cycle; bit 0 in the 16th.
//    DONE : o=0; on lrck_edge && i_en -> latch i_dac_data, go DELAY (next channel).
//  - Latency: the MSB appears on o 2 rising edges after the edge that samples the new
//    i_daclrck level. The detect cycle latches the data; DELAY drives 0; SEND drives the MSB.
//  - The sample is latched at frame start. Changes to i_dac_data mid-word do not affect
//    the word in flight.
//  - lrck_edge during DELAY/SEND (short frame): abort the current word, re-latch i_dac_data,
//    go DELAY. The remaining bits are dropped.
//  - i_en==0 in any state: next state IDLE, o=0 next cycle (word truncated). Re-enabling
//    waits for the next lrck_edge; a half-frame is never started mid-channel.
//  - o_aud_dacdat is a registered output; no combinational path from inputs.
//  - Frames longer than 18 BCLK simply idle at 0 in DONE (codec ignores trailing bits).
// STRUCTURE
//  - Package aud_pkg: typedef enum logic [1:0] {IDLE,DELAY,SEND,DONE} aud_state_e;
//    localparam DATA_W=16; localparam CNT_W=$clog2(DATA_W).
//  - Single module; an optional tiny sub-module lrck_edge_det (registered compare) may be
//    factored out, shared with the ADC recorder.
// TESTING
//  - Reset: i_rst_n=0 for 1 cycle, i_daclrck=1 -> o=0, state IDLE, no spurious start
//    after release.
//  - Left word: i_en=1, i_dac_data=16'hAAAA, i_daclrck 1->0 -> o = 0 (delay) then
//    1,0,1,0... (16 bits) then 0 until the next LRCK edge.
//  - Right word: LRCK 0->1 after 20 BCLK with i_dac_data=16'h8001 -> o = 0, then 1,
//    fourteen 0s, 1, then 0.
//  - Enable gating: i_en=0 with LRCK toggling every 20 BCLK -> o stays 0. Raising i_en
//    mid-channel -> no output until the next edge.
//  - Disable mid-word: drop i_en after 5 bits of 16'hFFFF -> o=0 from the next cycle,
//    state IDLE.
//  - Short frame: LRCK toggles 8 BCLK after the previous edge -> word aborted, new sample
//    latched, MSB 2 cycles later.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared types and sizing for the codec audio serialiser/recorder blocks.
// Width and counter sizing live here so player and recorder agree.
package aud_pkg;
    localparam int DATA_W = 16;
    localparam int CNT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        SEND,
        DONE
    } aud_state_e;
endpackage

// File: rtl/aud_player_lrck_edge_det.sv
// LRCK edge detector: registered copy of LRCK compared against the live level.
// Latency: edge flagged combinationally in the cycle the new level is sampled; no backpressure.
// Either polarity counts. The register always tracks LRCK, so no false edge follows reset.
module lrck_edge_det (
    input  logic i_clk,
    input  logic i_lrck,
    output logic o_edge
);
    logic r_lrck_q;

    always_ff @(posedge i_clk) begin
        r_lrck_q <= i_lrck;
    end

    assign o_edge = (i_lrck != r_lrck_q);
endmodule

// File: rtl/aud_player.sv
// I2S DAC serialiser: sends each PCM sample MSB-first on both channels of the WM8731.
// Latency: MSB on o_aud_dacdat two BCLK edges after the LRCK change is sampled; no backpressure.
// A new LRCK edge or a low i_en aborts the word in flight; the codec paces everything.
module aud_player
    import aud_pkg::*;
(
    input  logic              i_bclk,
    input  logic              i_rst_n,
    input  logic              i_daclrck,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_dac_data,
    output logic              o_aud_dacdat
);
    aud_state_e         r_state;
    aud_state_e         w_state_nxt;
    logic [DATA_W-1:0]  r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_dacdat;
    logic               w_dat_nxt;
    logic               w_load;
    logic               w_lrck_edge;

    lrck_edge_det u_edge (
        .i_clk  (i_bclk),
        .i_lrck (i_daclrck),
        .o_edge (w_lrck_edge)
    );

    always_ff @(posedge i_bclk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An LRCK edge always wins over the current state, so a short frame restarts cleanly.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_dat_nxt   = 1'b0;
        if (!i_en) begin
            w_state_nxt = IDLE;
        end else if (w_lrck_edge) begin
            w_state_nxt = DELAY;
            w_load      = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                DELAY: begin
                    w_state_nxt = SEND;
                    w_cnt_nxt   = CNT_W'(DATA_W - 1);
                end
                SEND: begin
                    w_dat_nxt = r_shift[r_cnt];
                    if (r_cnt == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    w_state_nxt = DONE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_bclk) begin
        if (!i_rst_n) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_dacdat <= 1'b0;
        end else begin
            if (w_load) begin
                r_shift <= i_dac_data;
            end
            r_cnt    <= w_cnt_nxt;
            r_dacdat <= w_dat_nxt;
        end
    end

    assign o_aud_dacdat = r_dacdat;
endmodule

// File: tb/tb_aud_player.sv
// Bench for aud_player: directed vector table, hand-written corner sequences and random traffic.
// Every cycle is also compared against a bit-schedule reference model.
module tb_aud_player;
    import aud_pkg::*;

    typedef struct {
        logic        en;
        logic        lrck;
        logic [15:0] data;
        logic        exp;
    } vec_t;

    logic        bclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        daclrck = 1'b1;
    logic        en = 1'b0;
    logic [15:0] dac_data = 16'h0000;
    logic        dacdat;

    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: a frame start schedules "one silent slot, then the 16 bits" on future cycles.
    int   sched[$];
    logic m_prev_lrck = 1'b1;
    logic m_o = 1'b0;

    vec_t tab[40];

    aud_player dut (
        .i_bclk       (bclk),
        .i_rst_n      (rst_n),
        .i_daclrck    (daclrck),
        .i_en         (en),
        .i_dac_data   (dac_data),
        .o_aud_dacdat (dacdat)
    );

    always #5 bclk = ~bclk;

    task automatic tick(input logic rn, input logic e, input logic lr, input logic [15:0] d,
                        input int exp, input string nm);
        rst_n    = rn;
        en       = e;
        daclrck  = lr;
        dac_data = d;
        @(posedge bclk);
        if (!rn || !e) begin
            sched.delete();
            m_o = 1'b0;
        end else if (lr != m_prev_lrck) begin
            sched.delete();
            sched.push_back(0);
            for (int b = 15; b >= 0; b--) sched.push_back(int'(d[b]));
            m_o = 1'b0;
        end else if (sched.size() > 0) begin
            m_o = logic'(sched.pop_front());
        end else begin
            m_o = 1'b0;
        end
        m_prev_lrck = lr;
        @(negedge bclk);
        n_checks++;
        if (dacdat !== m_o) begin
            n_errors++;
            $display("FAIL %s model: dacdat=%b expected=%b at %0t", nm, dacdat, m_o, $time);
        end
        if (exp >= 0) begin
            n_checks++;
            if (dacdat !== logic'(exp)) begin
                n_errors++;
                $display("FAIL %s vector: dacdat=%b expected=%0d at %0t", nm, dacdat, exp, $time);
            end
        end
    endtask

    task automatic check_idle(input string nm);
        n_checks++;
        if (dut.r_state !== IDLE) begin
            n_errors++;
            $display("FAIL %s state: got=%0d expected=IDLE(%0d)", nm, dut.r_state, IDLE);
        end
    endtask

    initial begin
        logic [15:0] w_left;
        logic [15:0] w_right;
        logic [15:0] w_ff;
        logic [15:0] w_c3;
        logic        r_lr;
        logic        r_en;
        int          rem;

        w_left  = 16'hAAAA;
        w_right = 16'h8001;
        w_ff    = 16'hFFFF;
        w_c3    = 16'hC3C3;
        for (int i = 0; i < 20; i++) begin
            tab[i].en   = 1'b1;
            tab[i].lrck = 1'b0;
            tab[i].data = (i == 0) ? w_left : 16'h5555;
            tab[i].exp  = (i >= 2 && i < 18) ? w_left[17-i] : 1'b0;
            tab[20+i].en   = 1'b1;
            tab[20+i].lrck = 1'b1;
            tab[20+i].data = (i == 0) ? w_right : 16'h7FFE;
            tab[20+i].exp  = (i >= 2 && i < 18) ? w_right[17-i] : 1'b0;
        end

        // Reset with LRCK high, then no spurious start once released.
        tick(1'b0, 1'b1, 1'b1, w_left, 0, "reset");
        check_idle("reset");
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, w_left, 0, "post_reset");
        check_idle("post_reset");

        // Left word 0xAAAA then right word 0x8001; data changes mid-word must not leak.
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, tab[i].en, tab[i].lrck, tab[i].data, int'(tab[i].exp),
                 (i < 20) ? "left_word" : "right_word");
        end

        // Disabled: LRCK keeps toggling, nothing comes out.
        for (int i = 0; i < 60; i++) begin
            tick(1'b1, 1'b0, ((i / 20) % 2 == 0) ? 1'b0 : 1'b1, w_ff, 0, "en_gate");
        end
        // Enable mid-channel: must wait for the next edge.
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, w_ff, 0, "en_midchan");

        // Disable after five bits of 0xFFFF.
        tick(1'b1, 1'b1, 1'b1, w_ff, 0, "dis_edge");
        tick(1'b1, 1'b1, 1'b1, w_ff, 0, "dis_delay");
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1, w_ff, 1, "dis_bits");
        tick(1'b1, 1'b0, 1'b1, w_ff, 0, "dis_drop");
        check_idle("dis_drop");
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, w_ff, 0, "dis_after");
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1, w_ff, 0, "reen_noedge");

        // Short frame: new edge 8 BCLK into a word aborts it and restarts with new data.
        tick(1'b1, 1'b1, 1'b0, 16'h1234, 0, "short_edge1");
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 1'b0, 16'h0000, -1, "short_word1");
        tick(1'b1, 1'b1, 1'b1, w_c3, 0, "short_edge2");
        tick(1'b1, 1'b1, 1'b1, 16'h0000, 0, "short_delay");
        tick(1'b1, 1'b1, 1'b1, 16'h0000, 1, "short_msb");
        tick(1'b1, 1'b1, 1'b1, 16'h0000, 1, "short_bit14");
        tick(1'b1, 1'b1, 1'b1, 16'h0000, 0, "short_bit13");
        for (int i = 0; i < 16; i++) tick(1'b1, 1'b1, 1'b1, 16'h0000, -1, "short_rest");

        // Random frames, enables, resets and data, checked only against the model.
        r_lr = 1'b1;
        r_en = 1'b1;
        rem  = 10;
        for (int i = 0; i < 4000; i++) begin
            rem--;
            if (rem == 0) begin
                r_lr = ~r_lr;
                rem  = int'($urandom_range(6, 40));
            end
            if ($urandom_range(0, 59) == 0) r_en = ~r_en;
            tick(($urandom_range(0, 499) != 0), r_en, r_lr, 16'($urandom), -1, "random");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
